// File: rtl/i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : common (package)
// Description : Shared I2S types and helpers: the serial bus bundle, the
//               sample-width selector, frame geometry and a width-to-mask
//               helper used when a stereo pair is loaded into a frame.
// Contents    : I2S_FRAME_BITS, I2S_SLOT_BITS, BITNUM, I2S,
//               bitnum_width(), bitnum_mask()
// Revision    : 1.0 - initial release
// ============================================================================
package common;

  localparam int I2S_FRAME_BITS = 64;
  localparam int I2S_SLOT_BITS  = 32;

  // Significant sample width; 2'b11 is reserved and behaves as 32 bits.
  typedef enum logic [1:0] {
    BITNUM_B16  = 2'b00,
    BITNUM_B24  = 2'b01,
    BITNUM_B32  = 2'b10,
    BITNUM_RSVD = 2'b11
  } BITNUM;

  // Serial bus bundle, packed as {bck, lrck, data}.
  typedef struct packed {
    logic bck;
    logic lrck;
    logic data;
  } I2S;

  function automatic int bitnum_width(input BITNUM bn);
    case (bn)
      BITNUM_B16: return 16;
      BITNUM_B24: return 24;
      default:    return 32;
    endcase
  endfunction

  // Keeps the top N bits of an MSB-aligned slot, zeroes the rest.
  function automatic logic [I2S_SLOT_BITS-1:0] bitnum_mask(input BITNUM bn);
    int w_unused_bits;
    w_unused_bits = I2S_SLOT_BITS - bitnum_width(bn);
    return ~((32'd1 << w_unused_bits) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_tx_bck_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_bck_gen
// Description : Bit-clock generator. Divides clk by 2*BCK_DIV while enabled.
//               The strobes are asserted during the clk cycle whose closing
//               rising edge makes bck toggle, so logic registering on a
//               strobe changes its outputs on the same edge as bck.
// Ports       : clk      - master clock
//               rst_n    - asynchronous active-low reset
//               en       - run enable; 0 holds bck low and the divider at 0
//               bck      - bit clock (registered)
//               fall_stb - bck goes 1->0 at the end of this cycle
//               rise_stb - bck goes 0->1 at the end of this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_bck_gen #(
  parameter int BCK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int              DIV_W      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(BCK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_bck;
  logic             w_term;

  assign w_term   = en && (r_div_cnt == c_div_last);
  assign fall_stb = w_term && r_bck;
  assign rise_stb = w_term && !r_bck;
  assign bck      = r_bck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else if (!en) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_bck     <= ~r_bck;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx
// Description : Philips I2S master transmitter, 64-bck frame (32 slots per
//               channel). One stereo pair is consumed per frame through a
//               valid/ready handshake and shifted out MSB first with the
//               standard one-bck delay after each lrck transition.
// Ports       : clk      - master clock
//               rst_n    - asynchronous active-low reset
//               en       - enable; 0 aborts the frame and idles the bus
//               bitnum   - sample width select, taken at frame load
//               s_valid  - sample pair valid
//               s_ready  - pair accepted this cycle when s_valid=1
//               s_left   - left sample, MSB aligned
//               s_right  - right sample, MSB aligned
//               i2s      - serial bus {bck, lrck, data}
//               underrun - frame loaded without a valid pair (mute frame)
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx
  import common::*;
#(
  parameter int BCK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  bitnum,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_left,
  input  logic [31:0] s_right,
  output logic [2:0]  i2s,
  output logic        underrun
);

  localparam int POS_W = $clog2(I2S_FRAME_BITS);

  logic                      w_bck;
  logic                      w_fall;
  logic                      w_rise_unused;
  logic                      w_load;
  logic [I2S_SLOT_BITS-1:0]  w_mask;
  logic [I2S_FRAME_BITS-1:0] w_shift_nxt;
  logic [POS_W-1:0]          w_pos_nxt;
  I2S                        w_bus;

  logic [POS_W-1:0]          r_pos;
  logic [I2S_FRAME_BITS-1:0] r_shift;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bck      (w_bck),
    .fall_stb (w_fall),
    .rise_stb (w_rise_unused)
  );

  // The load happens on the falling edge entering p=1, one bck after lrck
  // drops, which produces the I2S one-bit delay.
  assign w_load    = w_fall && (r_pos == '0);
  assign s_ready   = w_load;
  assign underrun  = w_load && !s_valid;
  assign w_pos_nxt = r_pos + POS_W'(1);

  // Mask derives from bitnum at the load cycle only, so a mid-frame change
  // cannot alter bits already latched into the shift register.
  assign w_mask = bitnum_mask(BITNUM'(bitnum));

  always_comb begin
    w_shift_nxt = {r_shift[I2S_FRAME_BITS-2:0], 1'b0};
    if (w_load) begin
      if (s_valid) begin
        w_shift_nxt = {s_left & w_mask, s_right & w_mask};
      end else begin
        w_shift_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_shift <= '0;
    end else if (!en) begin
      r_pos   <= '0;
      r_shift <= '0;
    end else if (w_fall) begin
      r_pos   <= w_pos_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // data is the shift MSB and lrck is the upper half of the frame counter;
  // both are flops updated on the same edge that drops bck.
  assign w_bus = '{bck: w_bck, lrck: r_pos[POS_W-1], data: r_shift[I2S_FRAME_BITS-1]};
  assign i2s   = w_bus;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tx
// Description : Self-checking bench for i2s_tx. A table of stereo pairs with
//               hand-computed masked results is streamed back to back through
//               a BCK_DIV=2 instance; the serial stream is rebuilt from data
//               sampled on each bck rising edge. Hand-written sequences cover
//               reset, abort/re-enable and bit-clock rates of BCK_DIV=1 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

  typedef struct {
    logic [1:0]  bn;
    logic [1:0]  bn_mid;
    logic        vld;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
    logic        exp_ur;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  bitnum;
  logic        s_valid;
  logic [31:0] s_left;
  logic [31:0] s_right;

  logic        s_ready;
  logic [2:0]  i2s;
  logic        underrun;
  logic        rdy_1, ur_1, rdy_4, ur_4;
  logic [2:0]  i2s_1, i2s_4;

  int          total;
  int          bad;
  int          cyc;
  int          ur_cnt;
  int          last_rdy;
  int          rdy_cyc;
  logic [5:0]  p_trk;
  logic        prev_bck;
  logic        rise_seen;
  logic [63:0] rec;
  logic [63:0] lrec;

  vec_t        tbl [10];

  i2s_tx #(.BCK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .bitnum(bitnum), .s_valid(s_valid),
    .s_ready(s_ready), .s_left(s_left), .s_right(s_right), .i2s(i2s),
    .underrun(underrun)
  );

  i2s_tx #(.BCK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .bitnum(bitnum), .s_valid(s_valid),
    .s_ready(rdy_1), .s_left(s_left), .s_right(s_right), .i2s(i2s_1),
    .underrun(ur_1)
  );

  i2s_tx #(.BCK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .bitnum(bitnum), .s_valid(s_valid),
    .s_ready(rdy_4), .s_left(s_left), .s_right(s_right), .i2s(i2s_4),
    .underrun(ur_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // One clk: inputs set before the call are seen by the coming rising edge;
  // everything is sampled on the following falling edge.
  task automatic step();
    logic en_prev;
    en_prev = en;
    @(negedge clk);
    cyc++;
    rise_seen = 1'b0;
    if (!en_prev) begin
      p_trk = 6'd0;
    end else if (prev_bck && !i2s[2]) begin
      p_trk = p_trk + 6'd1;
    end
    if (!prev_bck && i2s[2]) begin
      rise_seen   = 1'b1;
      rec[p_trk]  = i2s[0];
      lrec[p_trk] = i2s[1];
    end
    prev_bck = i2s[2];
    if (underrun) ur_cnt++;
  endtask

  task automatic do_frame(input vec_t v, input int idx, input bit chk_space);
    bit          got;
    bit          mid_done;
    int          ur0;
    logic [31:0] cl, cr;
    bitnum  = v.bn;
    s_valid = v.vld;
    s_left  = v.l;
    s_right = v.r;
    ur0     = ur_cnt;
    got     = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      step();
      if (s_ready) got = 1'b1;
    end
    check("ready_seen", idx, 64'(got), 64'd1);
    check("underrun_at_load", idx, 64'(underrun), 64'(v.exp_ur));
    if (chk_space && last_rdy >= 0) check("ready_spacing", idx, 64'(cyc - last_rdy), 64'd256);
    last_rdy = cyc;
    rdy_cyc  = cyc;
    step();
    check("ready_width", idx, 64'(s_ready), 64'd0);
    got      = 1'b0;
    mid_done = 1'b0;
    for (int n = 0; n < 2000 && !got; n++) begin
      step();
      if (!mid_done && p_trk == 6'd10) begin
        bitnum   = v.bn_mid;
        mid_done = 1'b1;
      end
      if (rise_seen && p_trk == 6'd0) got = 1'b1;
    end
    check("frame_end_seen", idx, 64'(got), 64'd1);
    for (int k = 0; k < 32; k++) cl[31-k] = rec[1+k];
    for (int k = 0; k < 31; k++) cr[31-k] = rec[33+k];
    cr[0] = rec[0];
    check("left_bits", idx, 64'(cl), 64'(v.exp_l));
    check("right_bits", idx, 64'(cr), 64'(v.exp_r));
    check("lrck_pattern", idx, lrec, 64'hFFFF_FFFF_0000_0000);
    check("underrun_count", idx, 64'(ur_cnt - ur0), 64'(v.exp_ur));
  endtask

  initial begin
    int   en_cyc;
    int   ur0;
    int   rdy_hits;
    bit   got;
    int   a1r [2];
    int   a1y [2];
    int   a4r [2];
    int   a4y [2];
    int   n1r, n1y, n4r, n4y;
    logic p1, p4;
    bit   y1_pend;
    logic y1_after;

    //        bn     bn_mid vld l              r              exp_l          exp_r          ur
    tbl[0] = '{2'b00, 2'b00, 1'b1, 32'hA5A5_0000, 32'h3C3C_0000, 32'hA5A5_0000, 32'h3C3C_0000, 1'b0};
    tbl[1] = '{2'b00, 2'b00, 1'b1, 32'hA5A5_1234, 32'h3C3C_FFFF, 32'hA5A5_0000, 32'h3C3C_0000, 1'b0};
    tbl[2] = '{2'b10, 2'b10, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[3] = '{2'b10, 2'b10, 1'b1, 32'h8000_0001, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 1'b0};
    tbl[4] = '{2'b01, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FF00, 32'h1234_5600, 1'b0};
    tbl[5] = '{2'b00, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'hFFFF_0000, 1'b0};
    tbl[6] = '{2'b10, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[7] = '{2'b10, 2'b10, 1'b1, 32'hCAFE_BABE, 32'h0F0F_F0F0, 32'hCAFE_BABE, 32'h0F0F_F0F0, 1'b0};
    tbl[8] = '{2'b11, 2'b11, 1'b1, 32'hFFFF_FFFF, 32'h8765_4321, 32'hFFFF_FFFF, 32'h8765_4321, 1'b0};
    tbl[9] = '{2'b01, 2'b01, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 32'h1357_9B00, 32'h2468_AC00, 1'b0};

    total = 0; bad = 0; cyc = 0; ur_cnt = 0; last_rdy = -1; rdy_cyc = 0;
    p_trk = 6'd0; prev_bck = 1'b0; rise_seen = 1'b0; rec = '0; lrec = '0;
    rst_n = 1'b0; en = 1'b0; bitnum = 2'b00; s_valid = 1'b0;
    s_left = '0; s_right = '0;

    // Reset state
    repeat (3) step();
    check("reset_i2s", 0, 64'(i2s), 64'd0);
    check("reset_ready", 0, 64'(s_ready), 64'd0);
    check("reset_underrun", 0, 64'(underrun), 64'd0);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle_i2s", 0, 64'(i2s), 64'd0);

    // First bck edge is a rise BCK_DIV clk after en is seen
    en     = 1'b1;
    en_cyc = cyc;
    step();
    check("first_bck_low", 0, 64'(i2s[2]), 64'd0);
    step();
    check("first_bck_rise", 0, 64'(i2s[2]), 64'd1);

    // Back-to-back frames from the table, s_valid held except where cleared
    for (int i = 0; i < 9; i++) begin
      do_frame(tbl[i], i, 1'b1);
      if (i == 0) check("first_load_latency", 0, 64'(rdy_cyc - en_cyc), 64'd3);
    end

    // Abort at p=40, then re-enable
    s_valid = 1'b1;
    got     = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      step();
      if (p_trk == 6'd40) got = 1'b1;
    end
    check("reach_p40", 0, 64'(got), 64'd1);
    ur0 = ur_cnt;
    en  = 1'b0;
    step();
    check("abort_i2s", 0, 64'(i2s), 64'd0);
    check("abort_ready", 0, 64'(s_ready), 64'd0);
    rdy_hits = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (s_ready) rdy_hits++;
    end
    check("abort_idle_ready", 0, 64'(rdy_hits), 64'd0);
    check("abort_idle_i2s", 0, 64'(i2s), 64'd0);
    en     = 1'b1;
    en_cyc = cyc;
    do_frame(tbl[9], 9, 1'b0);
    check("reenable_latency", 9, 64'(rdy_cyc - en_cyc), 64'd3);
    check("abort_no_underrun", 9, 64'(ur_cnt - ur0), 64'd0);

    // Bit-clock period and pair rate for BCK_DIV=1 and 4
    n1r = 0; n1y = 0; n4r = 0; n4y = 0;
    a1r = '{0, 0}; a1y = '{0, 0}; a4r = '{0, 0}; a4y = '{0, 0};
    y1_pend = 1'b0; y1_after = 1'b1;
    p1 = i2s_1[2];
    p4 = i2s_4[2];
    for (int n = 0; n < 2000 && !(n1r == 2 && n1y == 2 && n4r == 2 && n4y == 2); n++) begin
      step();
      if (y1_pend) begin
        y1_after = rdy_1;
        y1_pend  = 1'b0;
      end
      if (!p1 && i2s_1[2] && n1r < 2) begin a1r[n1r] = cyc; n1r++; end
      if (!p4 && i2s_4[2] && n4r < 2) begin a4r[n4r] = cyc; n4r++; end
      if (rdy_1 && n1y < 2) begin
        a1y[n1y] = cyc;
        if (n1y == 0) y1_pend = 1'b1;
        n1y++;
      end
      if (rdy_4 && n4y < 2) begin a4y[n4y] = cyc; n4y++; end
      p1 = i2s_1[2];
      p4 = i2s_4[2];
    end
    check("div1_bck_period", 1, 64'(a1r[1] - a1r[0]), 64'd2);
    check("div1_ready_spacing", 1, 64'(a1y[1] - a1y[0]), 64'd128);
    check("div1_ready_width", 1, 64'(y1_after), 64'd0);
    check("div4_bck_period", 4, 64'(a4r[1] - a4r[0]), 64'd8);
    check("div4_ready_spacing", 4, 64'(a4y[1] - a4y[0]), 64'd512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
